// File: rtl/gf3m_pe.sv
// GF(3^593) processing element: Horner digit-serial multiply (3 digits/cycle),
// Frobenius cube, add and subtract, all reduced mod x^M + x^POLY_K + 2 into ACC.
module gf3m_pe #(
    parameter int M      = 593,
    parameter int POLY_K = 243,
    parameter int D0W    = 1188
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [10:0]      ctrl,
    input  logic [D0W-1:0]   d0,
    input  logic [2*M-1:0]   d1,
    input  logic [2*M-1:0]   d2,
    output logic [2*M-1:0]   out
);
    localparam int E  = 2 * M;
    localparam int CW = 3 * M - 2;
    localparam logic [E-1:0] ZERO = {E{1'b0}};

    function automatic logic [1:0] dnorm(input logic [1:0] a);
        return (a == 2'b11) ? 2'b00 : a;
    endfunction

    function automatic logic [1:0] dadd(input logic [1:0] a, input logic [1:0] b);
        logic [2:0] s;
        s = {1'b0, dnorm(a)} + {1'b0, dnorm(b)};
        if (s >= 3'd3) s = s - 3'd3;
        return s[1:0];
    endfunction

    function automatic logic [1:0] dmul(input logic [1:0] a, input logic [1:0] b);
        logic [1:0] na;
        logic [1:0] nb;
        na = dnorm(a);
        nb = dnorm(b);
        if (na == 2'b00 || nb == 2'b00) return 2'b00;
        else if (na == nb) return 2'b01;
        else return 2'b10;
    endfunction

    function automatic logic [1:0] dneg(input logic [1:0] a);
        logic [1:0] n;
        n = dnorm(a);
        return {n[0], n[1]};
    endfunction

    function automatic logic [E-1:0] vadd(input logic [E-1:0] a, input logic [E-1:0] b);
        logic [E-1:0] r;
        for (int i = 0; i < M; i++) r[2*i +: 2] = dadd(a[2*i +: 2], b[2*i +: 2]);
        return r;
    endfunction

    function automatic logic [E-1:0] vscale(input logic [E-1:0] v, input logic [1:0] s);
        logic [E-1:0] r;
        for (int i = 0; i < M; i++) r[2*i +: 2] = dmul(v[2*i +: 2], s);
        return r;
    endfunction

    // Multiply by x: the digit leaving position M-1 folds back as 2*x^POLY_K + 1.
    function automatic logic [E-1:0] vmulx(input logic [E-1:0] v);
        logic [1:0]   top;
        logic [E-1:0] r;
        top = dnorm(v[E-1 -: 2]);
        r = {v[E-3:0], 2'b00};
        r[1:0] = top;
        r[2*POLY_K +: 2] = dadd(r[2*POLY_K +: 2], dneg(top));
        return r;
    endfunction

    // Frobenius: spread r_i to x^(3i), then fold the high part down from the top.
    function automatic logic [E-1:0] vcube(input logic [E-1:0] v);
        logic [1:0]   t [CW];
        logic [E-1:0] r;
        for (int j = 0; j < CW; j++) t[j] = 2'b00;
        for (int i = 0; i < M; i++) t[3*i] = dnorm(v[2*i +: 2]);
        for (int j = CW - 1; j >= M; j--) begin
            t[j-M+POLY_K] = dadd(t[j-M+POLY_K], dneg(t[j]));
            t[j-M]        = dadd(t[j-M], t[j]);
        end
        for (int i = 0; i < M; i++) r[2*i +: 2] = t[i];
        return r;
    endfunction

    logic [D0W-1:0] r0_r;
    logic [E-1:0]   r1_r, r2_r, acc_r;
    logic [1:0]     a2_s, a1_s, a0_s;
    logic [E-1:0]   cube_s, accx3_s, r1x2_s, r2x_s;
    logic [E-1:0]   t_acc_s, t_a2_s, t_a1_s, t_a0_s, result_s;

    assign a2_s    = r0_r[D0W-1 -: 2];
    assign a1_s    = r0_r[D0W-3 -: 2];
    assign a0_s    = r0_r[D0W-5 -: 2];
    assign cube_s  = vcube(r1_r);
    assign accx3_s = vmulx(vmulx(vmulx(acc_r)));
    assign r1x2_s  = vmulx(vmulx(r1_r));
    assign r2x_s   = vmulx(r2_r);

    // Select the terms of the ACC update; ctrl[6] is reserved and ignored.
    always_comb begin
        t_acc_s = ZERO;
        t_a2_s  = ZERO;
        t_a1_s  = ZERO;
        t_a0_s  = vscale(r1_r, a0_s);
        casez (ctrl[6:3])
            4'b???1: begin
                t_acc_s = ctrl[2] ? accx3_s : ZERO;
                t_a2_s  = ctrl[5] ? vscale(r1x2_s, a2_s) : ZERO;
                t_a1_s  = ctrl[4] ? vscale(r2x_s, a1_s) : ZERO;
            end
            4'b?1?0, 4'b?010: begin
                t_acc_s = ctrl[2] ? acc_r : ZERO;
                t_a2_s  = ctrl[5] ? vscale(r1_r, a2_s) : ZERO;
                t_a1_s  = ctrl[4] ? vscale(r2_r, a1_s) : ZERO;
            end
            4'b?000: begin
                t_acc_s = ctrl[2] ? acc_r : ZERO;
                t_a0_s  = vscale(cube_s, a0_s);
            end
            default: begin
                t_acc_s = ZERO;
            end
        endcase
        result_s = vadd(vadd(t_acc_s, t_a2_s), vadd(t_a1_s, t_a0_s));
    end

    // Operand and accumulator registers; load beats shift, clear beats write.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r0_r  <= {D0W{1'b0}};
            r1_r  <= ZERO;
            r2_r  <= ZERO;
            acc_r <= ZERO;
        end else begin
            if (ctrl[10])     r0_r <= d0;
            else if (ctrl[1]) r0_r <= {r0_r[D0W-7:0], 6'b000000};
            else              r0_r <= r0_r;
            if (ctrl[9]) r1_r <= d1;
            else         r1_r <= r1_r;
            if (ctrl[8]) r2_r <= d2;
            else         r2_r <= r2_r;
            if (ctrl[7])      acc_r <= ZERO;
            else if (ctrl[0]) acc_r <= result_s;
            else              acc_r <= acc_r;
        end
    end

    assign out = acc_r;

endmodule

// File: tb/tb_gf3m_pe.sv
// Self-checking bench for gf3m_pe: vector table for add/sub/cube, hand sequences
// for multiply, reset, clear priority and accumulate, plus random multiplies.
module tb_gf3m_pe;
    localparam int M     = 593;
    localparam int K     = 243;
    localparam int D0W   = 1188;
    localparam int E     = 2 * M;
    localparam int STEPS = 198;

    logic           clk = 1'b0;
    logic           reset;
    logic [10:0]    ctrl;
    logic [D0W-1:0] d0;
    logic [E-1:0]   d1, d2, out;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    gf3m_pe dut (.clk(clk), .reset(reset), .ctrl(ctrl), .d0(d0), .d1(d1), .d2(d2), .out(out));

    typedef struct {
        string        name;
        int           op;   // 0 add, 1 sub, 2 cube
        logic [E-1:0] a;
        logic [E-1:0] b;
        logic [E-1:0] exp;
    } vec_t;
    vec_t vecs[$];

    function automatic int dig(input logic [E-1:0] v, input int i);
        logic [1:0] d;
        d = v[2*i +: 2];
        return (d == 2'b11) ? 0 : int'(d);
    endfunction

    function automatic logic [E-1:0] mono(input int i, input logic [1:0] d);
        logic [E-1:0] r;
        r = {E{1'b0}};
        r[2*i +: 2] = d;
        return r;
    endfunction

    function automatic logic [E-1:0] rand_elem();
        logic [E-1:0] r;
        for (int i = 0; i < M; i++) r[2*i +: 2] = 2'($urandom_range(2));
        return r;
    endfunction

    // Reference: schoolbook product over the integers, then x^M -> 2x^K + 1, then mod 3.
    function automatic logic [E-1:0] ref_mul(input logic [E-1:0] a, input logic [E-1:0] b);
        int c [2*M-1];
        int av [M];
        int bv [M];
        logic [E-1:0] r;
        for (int i = 0; i < M; i++) begin
            av[i] = dig(a, i);
            bv[i] = dig(b, i);
        end
        for (int k = 0; k < 2*M-1; k++) c[k] = 0;
        for (int i = 0; i < M; i++)
            if (av[i] != 0)
                for (int j = 0; j < M; j++) c[i+j] += av[i] * bv[j];
        for (int k = 2*M-2; k >= M; k--) begin
            c[k] = c[k] % 3;
            c[k-M+K] += 2 * c[k];
            c[k-M]   += c[k];
            c[k] = 0;
        end
        for (int i = 0; i < M; i++) r[2*i +: 2] = 2'(c[i] % 3);
        return r;
    endfunction

    function automatic logic [E-1:0] ref_lin(input logic [E-1:0] a, input logic [E-1:0] b, input int sub);
        logic [E-1:0] r;
        for (int i = 0; i < M; i++)
            r[2*i +: 2] = 2'((dig(a, i) + (sub != 0 ? 2 : 1) * dig(b, i)) % 3);
        return r;
    endfunction

    function automatic logic [D0W-1:0] top6(input logic [5:0] t);
        return {t, {(D0W-6){1'b0}}};
    endfunction

    task automatic tick(input logic [10:0] c);
        ctrl = c;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [E-1:0] exp);
        int idx;
        total++;
        if (out !== exp) begin
            bad++;
            idx = 0;
            for (int i = M - 1; i >= 0; i--) if (out[2*i +: 2] !== exp[2*i +: 2]) idx = i;
            $display("FAIL %s: digit %0d got %b want %b", name, idx, out[2*idx +: 2], exp[2*idx +: 2]);
        end
    endtask

    task automatic add_vec(input string n, input int op, input logic [E-1:0] a,
                           input logic [E-1:0] b, input logic [E-1:0] e);
        vec_t v;
        v.name = n; v.op = op; v.a = a; v.b = b; v.exp = e;
        vecs.push_back(v);
    endtask

    task automatic start_mul(input logic [E-1:0] a, input logic [E-1:0] b, input int steps);
        d0 = {2'b00, a};
        d1 = b;
        d2 = b;
        tick(11'b11111_000000);
        for (int s = 0; s < steps; s++) tick(11'b00000_111111);
    endtask

    logic [E-1:0] a, b, e, s;

    initial begin
        reset = 1'b0;
        ctrl  = 11'd0;
        d0    = {D0W{1'b0}};
        d1    = {E{1'b0}};
        d2    = {E{1'b0}};

        add_vec("add 2+2", 0, mono(0, 2'b10), mono(0, 2'b10), mono(0, 2'b01));
        add_vec("sub 0-1", 1, {E{1'b0}}, mono(0, 2'b01), mono(0, 2'b10));
        add_vec("cube x200", 2, mono(200, 2'b01), {E{1'b0}}, mono(250, 2'b10) | mono(7, 2'b01));
        a = mono(592, 2'b10);
        add_vec("cube 2x592", 2, a, {E{1'b0}}, ref_mul(ref_mul(a, a), a));
        a = rand_elem();
        add_vec("add d2=11s", 0, a, {E{1'b1}}, a);
        for (int k = 0; k < 3; k++) begin
            a = rand_elem(); b = rand_elem();
            add_vec("add rnd", 0, a, b, ref_lin(a, b, 0));
            a = rand_elem(); b = rand_elem();
            add_vec("sub rnd", 1, a, b, ref_lin(a, b, 1));
        end
        for (int k = 0; k < 2; k++) begin
            a = rand_elem();
            add_vec("cube rnd", 2, a, {E{1'b0}}, ref_mul(ref_mul(a, a), a));
        end

        repeat (3) @(posedge clk);
        #1;
        check("reset out", {E{1'b0}});
        reset = 1'b1;

        foreach (vecs[i]) begin
            d0 = top6(vecs[i].op == 0 ? 6'b000101 : (vecs[i].op == 1 ? 6'b001001 : 6'b010101));
            d1 = vecs[i].a;
            d2 = vecs[i].b;
            tick(11'b11110_000000);
            tick(vecs[i].op == 2 ? 11'b00000_000001 : 11'b00000_010001);
            check(vecs[i].name, vecs[i].exp);
        end

        start_mul(mono(1, 2'b01), mono(0, 2'b01), STEPS);
        check("mul x*1", mono(1, 2'b01));
        start_mul(mono(1, 2'b01), mono(592, 2'b01), STEPS);
        e = mono(K, 2'b10) | mono(0, 2'b01);
        check("mul wrap", e);

        d0 = {D0W{1'b1}};
        d1 = rand_elem();
        d2 = rand_elem();
        tick(11'b11100_000000);
        check("reload keeps acc", e);

        a = rand_elem(); b = rand_elem();
        s = ref_lin(a, b, 0);
        d0 = top6(6'b000101); d1 = a; d2 = b;
        tick(11'b11110_000010);
        tick(11'b00000_010001);
        check("load beats shift", s);
        tick(11'b00000_010101);
        check("accumulate", ref_lin(s, s, 0));

        a = rand_elem();
        d0 = top6(6'b010101); d1 = a;
        tick(11'b11110_000000);
        tick(11'b00000_000001);
        check("cube before clear", ref_mul(ref_mul(a, a), a));
        tick(11'b00010_000001);
        check("clear priority", {E{1'b0}});

        a = rand_elem(); b = rand_elem();
        start_mul(a, b, 100);
        #2 reset = 1'b0;
        #1 check("async reset", {E{1'b0}});
        #1 reset = 1'b1;
        tick(11'b00000_111111);
        check("regs cleared", {E{1'b0}});
        start_mul(a, b, STEPS);
        check("mul after reset", ref_mul(a, b));

        for (int k = 0; k < 3; k++) begin
            a = rand_elem(); b = rand_elem();
            start_mul(a, b, STEPS);
            check("mul rnd", ref_mul(a, b));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
